// File: rtl/switch_pkg.sv
// Shared definitions for the device-side switch port master:
// default widths and the TX/RX state encodings.
package switch_pkg;

    localparam int AW_DEV_DEF = 2;
    localparam int DW_DEF     = 4;
    localparam int TO_W_DEF   = 4;
    localparam int CW_DEF     = 8;

    typedef logic [1:0] fsm_state_t;

    // TX handshake states
    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_REQ  = 2'd1;
    localparam logic [1:0] T_REL  = 2'd2;

    // RX handshake states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_GAP  = 2'd2;

endpackage

// File: rtl/dev_port_rx.sv
// Receive side of the device port: answers the switch port's validrx with
// ackrx, captures the FIFO head word and presents it on a local valid/ready
// interface. Counts captured words.
//
// state  | meaning
// -------+---------------------------------------------------------------
// R_IDLE | waiting for validrx with room in the local holding register
// R_ACK  | word captured, ackrx held until the port drops validrx
// R_GAP  | two cycles ignoring validrx (port view is two stages late)
module dev_port_rx
    import switch_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sw_validrx_i,
    input  logic [DW-1:0] sw_dat_i,
    output logic          sw_ackrx_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic [DW-1:0] rx_dat_o,
    input  logic          clr_i,
    output logic [CW-1:0] rx_cnt_o
);

    fsm_state_t    r_state;
    logic          r_gap;
    logic          r_ackrx;
    logic          r_rx_valid;
    logic [DW-1:0] r_rx_dat;
    logic [CW-1:0] r_rx_cnt;
    logic          w_capture;

    // A capture needs a free holding register, or one being emptied this cycle
    assign w_capture = (r_state == R_IDLE) && sw_validrx_i && (!r_rx_valid || rx_ready_i);

    // Handshake sequencing towards the port; r_gap counts remaining gap cycles
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= R_IDLE;
            r_gap   <= 1'b0;
            r_ackrx <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_capture) begin
                        r_state <= R_ACK;
                        r_ackrx <= 1'b1;
                    end
                end
                R_ACK: begin
                    if (!sw_validrx_i) begin
                        r_state <= R_GAP;
                        r_ackrx <= 1'b0;
                        r_gap   <= 1'b1;
                    end
                end
                R_GAP: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else begin
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    r_ackrx <= 1'b0;
                    r_gap   <= 1'b0;
                end
            endcase
        end
    end

    // Local holding register: a new capture overrides the consume-clear
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rx_valid <= 1'b0;
            r_rx_dat   <= '0;
        end else if (w_capture) begin
            r_rx_valid <= 1'b1;
            r_rx_dat   <= sw_dat_i;
        end else if (rx_ready_i) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Captured-word counter, clear has priority over increment
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rx_cnt <= '0;
        end else if (clr_i) begin
            r_rx_cnt <= '0;
        end else if (w_capture) begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
        end
    end

    assign sw_ackrx_o = r_ackrx;
    assign rx_valid_o = r_rx_valid;
    assign rx_dat_o   = r_rx_dat;
    assign rx_cnt_o   = r_rx_cnt;

endmodule

// File: rtl/dev_port_master.sv
// Device-side master for one switch port: 4-phase TX handshake with stall
// detection and TX counter, plus the RX drain path in dev_port_rx.
//
// state  | meaning
// -------+---------------------------------------------------------------
// T_IDLE | ready for a local word (tx_ready_o high)
// T_REQ  | validtx held with stable dat/adr until acktx
// T_REL  | validtx dropped, waiting for the port to release acktx
module dev_port_master
    import switch_pkg::*;
#(
    parameter int AW_DEV = AW_DEV_DEF,
    parameter int DW     = DW_DEF,
    parameter int TO_W   = TO_W_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DW-1:0]     tx_dat_i,
    input  logic [AW_DEV-1:0] tx_adr_i,
    output logic              sw_validtx_o,
    output logic [DW-1:0]     sw_dat_o,
    output logic [AW_DEV-1:0] sw_adr_o,
    input  logic              sw_acktx_i,
    input  logic              sw_validrx_i,
    input  logic [DW-1:0]     sw_dat_i,
    output logic              sw_ackrx_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [DW-1:0]     rx_dat_o,
    input  logic              clr_i,
    output logic              tx_stall_o,
    output logic [CW-1:0]     tx_cnt_o,
    output logic [CW-1:0]     rx_cnt_o
);

    fsm_state_t        r_tx_state;
    logic              r_tx_ready;
    logic              r_validtx;
    logic [DW-1:0]     r_dat;
    logic [AW_DEV-1:0] r_adr;
    logic [TO_W-1:0]   r_timer;
    logic              r_stall;
    logic [CW-1:0]     r_tx_cnt;
    logic              w_accept;
    logic              w_tx_done;

    assign w_accept  = (r_tx_state == T_IDLE) && r_tx_ready && tx_valid_i;
    assign w_tx_done = (r_tx_state == T_REQ) && sw_acktx_i;

    // TX handshake; ready is registered so it reads 0 through reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tx_state <= T_IDLE;
            r_tx_ready <= 1'b0;
            r_validtx  <= 1'b0;
            r_dat      <= '0;
            r_adr      <= '0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    r_tx_ready <= 1'b1;
                    if (w_accept) begin
                        r_tx_state <= T_REQ;
                        r_tx_ready <= 1'b0;
                        r_validtx  <= 1'b1;
                        r_dat      <= tx_dat_i;
                        r_adr      <= tx_adr_i;
                    end
                end
                T_REQ: begin
                    if (sw_acktx_i) begin
                        r_tx_state <= T_REL;
                        r_validtx  <= 1'b0;
                    end
                end
                T_REL: begin
                    if (!sw_acktx_i) begin
                        r_tx_state <= T_IDLE;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= T_IDLE;
                    r_tx_ready <= 1'b0;
                    r_validtx  <= 1'b0;
                end
            endcase
        end
    end

    // Stall down-counter: loaded on accept, flag fires once on the 1->0 step
    // so clr_i can drop the flag even while the request is still stuck
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_timer <= '0;
            r_stall <= 1'b0;
        end else begin
            if (w_accept) begin
                r_timer <= '1;
            end else if ((r_tx_state == T_REQ) && !sw_acktx_i) begin
                if (r_timer != '0) begin
                    r_timer <= r_timer - TO_W'(1);
                end
            end else begin
                r_timer <= '0;
            end

            if (clr_i) begin
                r_stall <= 1'b0;
            end else if ((r_tx_state == T_REQ) && (r_timer == TO_W'(1))) begin
                r_stall <= 1'b1;
            end
        end
    end

    // Completed-handshake counter, clear has priority over increment
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tx_cnt <= '0;
        end else if (clr_i) begin
            r_tx_cnt <= '0;
        end else if (w_tx_done) begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
        end
    end

    assign tx_ready_o   = r_tx_ready;
    assign sw_validtx_o = r_validtx;
    assign sw_dat_o     = r_dat;
    assign sw_adr_o     = r_adr;
    assign tx_stall_o   = r_stall;
    assign tx_cnt_o     = r_tx_cnt;

    dev_port_rx #(
        .DW (DW),
        .CW (CW)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sw_validrx_i (sw_validrx_i),
        .sw_dat_i     (sw_dat_i),
        .sw_ackrx_o   (sw_ackrx_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .rx_dat_o     (rx_dat_o),
        .clr_i        (clr_i),
        .rx_cnt_o     (rx_cnt_o)
    );

endmodule

// File: tb/tb_dev_port_master.sv
// Bench for dev_port_master with behavioural switch-port TX acker and a
// port output FIFO whose validrx is two register stages late.
module tb_dev_port_master;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [3:0] tx_dat_i;
    logic [1:0] tx_adr_i;
    logic       sw_validtx_o;
    logic [3:0] sw_dat_o;
    logic [1:0] sw_adr_o;
    logic       sw_acktx_i;
    logic       sw_validrx_i;
    logic [3:0] sw_dat_i;
    logic       sw_ackrx_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [3:0] rx_dat_o;
    logic       clr_i;
    logic       tx_stall_o;
    logic [7:0] tx_cnt_o;
    logic [7:0] rx_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dev_port_master #(
        .AW_DEV (2),
        .DW     (4),
        .TO_W   (4),
        .CW     (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .tx_dat_i     (tx_dat_i),
        .tx_adr_i     (tx_adr_i),
        .sw_validtx_o (sw_validtx_o),
        .sw_dat_o     (sw_dat_o),
        .sw_adr_o     (sw_adr_o),
        .sw_acktx_i   (sw_acktx_i),
        .sw_validrx_i (sw_validrx_i),
        .sw_dat_i     (sw_dat_i),
        .sw_ackrx_o   (sw_ackrx_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .rx_dat_o     (rx_dat_o),
        .clr_i        (clr_i),
        .tx_stall_o   (tx_stall_o),
        .tx_cnt_o     (tx_cnt_o),
        .rx_cnt_o     (rx_cnt_o)
    );

    // ---------------- switch port TX side: acks unless destination full
    logic       dest_full = 1'b0;
    logic       rand_ack  = 1'b0;
    logic [3:0] txlog_dat [0:63];
    logic [1:0] txlog_adr [0:63];
    int         txn = 0;

    always @(posedge clk) begin
        if (!rst_i) begin
            sw_acktx_i <= 1'b0;
        end else if (!sw_acktx_i) begin
            if (sw_validtx_o && !dest_full && (!rand_ack || ($urandom_range(0, 2) == 0))) begin
                sw_acktx_i          <= 1'b1;
                txlog_dat[txn[5:0]] <= sw_dat_o;
                txlog_adr[txn[5:0]] <= sw_adr_o;
                txn                 <= txn + 1;
            end
        end else if (!sw_validtx_o) begin
            sw_acktx_i <= 1'b0;
        end
    end

    // ---------------- switch port RX side: FIFO with 2-stage delayed validrx
    logic [3:0] fifo [0:63];
    int         wptr = 0;
    int         rptr = 0;
    logic       p_raw, p_v1, p_busy;

    assign sw_dat_i = fifo[rptr[5:0]];

    always @(posedge clk) begin
        if (!rst_i) begin
            rptr         <= wptr;
            p_raw        <= 1'b0;
            p_v1         <= 1'b0;
            p_busy       <= 1'b0;
            sw_validrx_i <= 1'b0;
        end else begin
            p_v1         <= p_raw;
            sw_validrx_i <= p_v1;
            if (p_busy) begin
                p_raw <= 1'b0;
                if (!sw_ackrx_o) p_busy <= 1'b0;
            end else if (sw_ackrx_o) begin
                rptr   <= rptr + 1;
                p_raw  <= 1'b0;
                p_busy <= 1'b1;
            end else begin
                p_raw <= (rptr != wptr);
            end
        end
    end

    // ---------------- local consumer log and protocol monitors
    logic [3:0] rxlog [0:63];
    int         rxn = 0;
    logic       prev_v = 1'b0;
    logic [3:0] prev_d = 4'd0;
    logic [1:0] prev_a = 2'd0;
    int         stab_bad = 0;
    int         reraise_bad = 0;

    always @(posedge clk) begin
        if (rst_i && rx_valid_o && rx_ready_i) begin
            rxlog[rxn[5:0]] <= rx_dat_o;
            rxn             <= rxn + 1;
        end
    end

    always @(posedge clk) begin
        prev_v <= sw_validtx_o;
        prev_d <= sw_dat_o;
        prev_a <= sw_adr_o;
        if (rst_i && prev_v && sw_validtx_o && ((sw_dat_o != prev_d) || (sw_adr_o != prev_a)))
            stab_bad <= stab_bad + 1;
        if (rst_i && !prev_v && sw_validtx_o && sw_acktx_i)
            reraise_bad <= reraise_bad + 1;
    end

    // ---------------- helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic send(input logic [3:0] d, input logic [1:0] a);
        int n;
        n          = 0;
        tx_valid_i = 1'b1;
        tx_dat_i   = d;
        tx_adr_i   = a;
        while (!tx_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept_bound", 32'(n < 200), 32'd1);
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic push(input logic [3:0] d);
        fifo[wptr[5:0]] = d;
        wptr            = wptr + 1;
    endtask

    function automatic logic [3:0] tx_word(input int i);
        return 4'(i * 7 + 3);
    endfunction

    function automatic logic [3:0] rx_word(input int i);
        return 4'(i * 5 + 1);
    endfunction

    // ---------------- stimulus
    initial begin
        int n;
        int txb, rxb;
        rst_i      = 1'b0;
        tx_valid_i = 1'b0;
        tx_dat_i   = 4'd0;
        tx_adr_i   = 2'd0;
        rx_ready_i = 1'b0;
        clr_i      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({tx_ready_o, sw_validtx_o, sw_dat_o, sw_adr_o, sw_ackrx_o,
                                 rx_valid_o, rx_dat_o, tx_stall_o, tx_cnt_o, rx_cnt_o}), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(tx_ready_o), 32'd1);

        // 1: single TX word 0xA to address 2
        send(4'hA, 2'd2);
        chk("t1_validtx_rise", 32'(sw_validtx_o), 32'd1);
        chk("t1_dat", 32'(sw_dat_o), 32'hA);
        chk("t1_adr", 32'(sw_adr_o), 32'd2);
        chk("t1_not_ready", 32'(tx_ready_o), 32'd0);
        @(negedge clk);
        chk("t1_validtx_hold", 32'(sw_validtx_o), 32'd1);
        @(negedge clk);
        chk("t1_validtx_drop", 32'(sw_validtx_o), 32'd0);
        chk("t1_tx_cnt", 32'(tx_cnt_o), 32'd1);
        @(negedge clk);
        chk("t1_rel_not_ready", 32'(tx_ready_o), 32'd0);
        @(negedge clk);
        chk("t1_idle_ready", 32'(tx_ready_o), 32'd1);
        chk("t1_port_dat", 32'(txlog_dat[0]), 32'hA);
        chk("t1_port_adr", 32'(txlog_adr[0]), 32'd2);

        // 2: drain two words with the local side always ready
        push(4'h3);
        push(4'h5);
        rx_ready_i = 1'b1;
        n = 0;
        while (rxn < 2 && n < 200) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        chk("t2_rx_count", 32'(rxn), 32'd2);
        chk("t2_word0", 32'(rxlog[0]), 32'h3);
        chk("t2_word1", 32'(rxlog[1]), 32'h5);
        chk("t2_rx_cnt", 32'(rx_cnt_o), 32'd2);

        // 3: local backpressure with two words queued
        rx_ready_i = 1'b0;
        push(4'h3);
        push(4'h5);
        repeat (25) @(negedge clk);
        chk("t3_held_valid", 32'(rx_valid_o), 32'd1);
        chk("t3_held_dat", 32'(rx_dat_o), 32'h3);
        chk("t3_no_ack", 32'(sw_ackrx_o), 32'd0);
        chk("t3_one_capture", 32'(rx_cnt_o), 32'd3);
        rx_ready_i = 1'b1;
        n = 0;
        while (rxn < 4 && n < 200) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        chk("t3_rx_count", 32'(rxn), 32'd4);
        chk("t3_word2", 32'(rxlog[2]), 32'h3);
        chk("t3_word3", 32'(rxlog[3]), 32'h5);
        chk("t3_rx_cnt", 32'(rx_cnt_o), 32'd4);

        // 4: blocked destination, stall after 15 T_REQ cycles
        dest_full = 1'b1;
        send(4'h7, 2'd1);
        repeat (14) @(negedge clk);
        chk("t4_stall_early", 32'(tx_stall_o), 32'd0);
        chk("t4_validtx_14", 32'(sw_validtx_o), 32'd1);
        @(negedge clk);
        chk("t4_stall_set", 32'(tx_stall_o), 32'd1);
        repeat (5) @(negedge clk);
        chk("t4_req_held", 32'(sw_validtx_o), 32'd1);
        dest_full = 1'b0;
        n = 0;
        while (tx_cnt_o != 8'd2 && n < 100) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk("t4_tx_cnt", 32'(tx_cnt_o), 32'd2);
        chk("t4_port_dat", 32'(txlog_dat[1]), 32'h7);
        chk("t4_port_adr", 32'(txlog_adr[1]), 32'd1);
        chk("t4_stall_sticky", 32'(tx_stall_o), 32'd1);
        chk("t4_idle_ready", 32'(tx_ready_o), 32'd1);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("t4_clr_stall", 32'(tx_stall_o), 32'd0);
        chk("t4_clr_tx_cnt", 32'(tx_cnt_o), 32'd0);
        chk("t4_clr_rx_cnt", 32'(rx_cnt_o), 32'd0);

        // 5: reset while TX is in T_REQ and RX is in R_ACK
        dest_full  = 1'b1;
        rx_ready_i = 1'b0;
        send(4'h6, 2'd0);
        push(4'h9);
        n = 0;
        while (!sw_ackrx_o && n < 50) begin @(negedge clk); n++; end
        chk("t5_ackrx_seen", 32'(sw_ackrx_o), 32'd1);
        chk("t5_validtx_before", 32'(sw_validtx_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("t5_rst_outputs", 32'({tx_ready_o, sw_validtx_o, sw_dat_o, sw_adr_o, sw_ackrx_o,
                                    rx_valid_o, rx_dat_o, tx_stall_o, tx_cnt_o, rx_cnt_o}), 32'd0);
        @(negedge clk);
        rst_i     = 1'b1;
        dest_full = 1'b0;
        @(negedge clk);
        send(4'hC, 2'd3);
        n = 0;
        while (tx_cnt_o != 8'd1 && n < 100) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk("t5_tx_cnt", 32'(tx_cnt_o), 32'd1);
        chk("t5_port_dat", 32'(txlog_dat[2]), 32'hC);
        chk("t5_port_adr", 32'(txlog_adr[2]), 32'd3);
        chk("t5_rx_idle", 32'(rx_valid_o), 32'd0);
        chk("t5_rx_cnt", 32'(rx_cnt_o), 32'd0);

        // 6: concurrent TX and RX streams with random stalls
        clr_i = 1'b1;
        @(negedge clk);
        clr_i    = 1'b0;
        rand_ack = 1'b1;
        txb      = txn;
        rxb      = rxn;
        for (int i = 0; i < 20; i++) push(rx_word(i));
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(tx_word(i), 2'(i));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                int k;
                k = 0;
                while (rxn < rxb + 20 && k < 3000) begin
                    rx_ready_i = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    k++;
                end
                rx_ready_i = 1'b1;
            end
        join
        n = 0;
        while (txn < txb + 20 && n < 500) begin @(negedge clk); n++; end
        repeat (15) @(negedge clk);
        chk("t6_tx_cnt", 32'(tx_cnt_o), 32'd20);
        chk("t6_rx_cnt", 32'(rx_cnt_o), 32'd20);
        chk("t6_tx_words", 32'(txn - txb), 32'd20);
        chk("t6_rx_words", 32'(rxn - rxb), 32'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t6_tx_dat_%0d", i), 32'(txlog_dat[6'(txb + i)]), 32'(tx_word(i)));
            chk($sformatf("t6_tx_adr_%0d", i), 32'(txlog_adr[6'(txb + i)]), 32'(i % 4));
            chk($sformatf("t6_rx_dat_%0d", i), 32'(rxlog[6'(rxb + i)]), 32'(rx_word(i)));
        end

        chk("dat_adr_stable", 32'(stab_bad), 32'd0);
        chk("no_raise_under_ack", 32'(reraise_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
